ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 31 +++
 rtl/rr_arbiter2.sv | 32 +++
 rtl/ram_arbiter.sv | 131 +++++++++++++
 tb/tb_ram_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
// Holds the FSM state encoding and the default RAM geometry.
package ram_arb_pkg;

   localparam int AW_DEF = 4;
   localparam int DW_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Winner of a two-way request: the tie goes to prio,
   // otherwise whichever side is actually asking.
   function automatic logic rr_pick(
      input logic r0,
      input logic r1,
      input logic prio
   );
      logic g;
      g = prio;
      if (!r1)
         g = 1'b0;
      else if (!r0)
         g = 1'b1;
      return g;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with a one-bit priority pointer.
// The pointer moves only when a grant is actually taken.
module rr_arbiter2
   import ram_arb_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   input  logic take,
   output logic valid,
   output logic grant
);

   logic prio;

   assign valid = req0 | req1;

   // Combinational winner for the current request pair
   always_comb begin
      grant = rr_pick(req0, req1, prio);
   end

   // Pointer favours the side that lost the last grant
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         prio <= 1'b0;
      else if (take && valid)
         prio <= ~grant;
   end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a single-port registered RAM.
// Each access walks IDLE -> ISSUE -> WAIT -> DONE.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          req0,
   input  logic          req1,
   input  logic          wr0,
   input  logic          wr1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic [AW-1:0] ram_address,
   output logic [DW-1:0] ram_dataIn,
   output logic          ram_we,
   output logic          ram_rd,
   input  logic [DW-1:0] ram_dataOut,
   output logic          busy
);

   state_t        state;
   logic          win;
   logic          wr_q;
   logic          any;
   logic          pick;
   logic          take;
   logic          sel_wr;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_data;

   assign take = (state == IDLE);

   rr_arbiter2 u_rr (
      .clock (clock),
      .reset (reset),
      .req0  (req0),
      .req1  (req1),
      .take  (take),
      .valid (any),
      .grant (pick)
   );

   // Mux the winning requester's command onto one bundle
   always_comb begin
      sel_wr   = wr0;
      sel_addr = addr0;
      sel_data = wdata0;
      unique case (1'b1)
         pick: begin
            sel_wr   = wr1;
            sel_addr = addr1;
            sel_data = wdata1;
         end
         default: ;
      endcase
   end

   // Access sequencer with registered strobes, acks and read data
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         win         <= 1'b0;
         wr_q        <= 1'b0;
         ram_address <= '0;
         ram_dataIn  <= '0;
         ram_we      <= 1'b0;
         ram_rd      <= 1'b0;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         rdata0      <= '0;
         rdata1      <= '0;
         busy        <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any) begin
                  state       <= ISSUE;
                  win         <= pick;
                  wr_q        <= sel_wr;
                  ram_address <= sel_addr;
                  ram_dataIn  <= sel_data;
                  ram_we      <= sel_wr;
                  ram_rd      <= ~sel_wr;
                  busy        <= 1'b1;
               end
            end
            ISSUE: begin
               ram_we <= 1'b0;
               ram_rd <= 1'b0;
               state  <= WAIT;
            end
            WAIT: begin
               if (!wr_q) begin
                  if (win)
                     rdata1 <= ram_dataOut;
                  else
                     rdata0 <= ram_dataOut;
               end
               ack0  <= ~win;
               ack1  <= win;
               state <= DONE;
            end
            DONE: begin
               ack0  <= 1'b0;
               ack1  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               ram_we <= 1'b0;
               ram_rd <= 1'b0;
               ack0   <= 1'b0;
               ack1   <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a registered RAM
// and a transaction-level model of the arbitration rules.
module tb_ram_arbiter;

   localparam int AW = 4;
   localparam int DW = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          req0 = 1'b0;
   logic          req1 = 1'b0;
   logic          wr0 = 1'b0;
   logic          wr1 = 1'b0;
   logic [AW-1:0] addr0 = '0;
   logic [AW-1:0] addr1 = '0;
   logic [DW-1:0] wdata0 = '0;
   logic [DW-1:0] wdata1 = '0;
   logic          ack0;
   logic          ack1;
   logic [DW-1:0] rdata0;
   logic [DW-1:0] rdata1;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_dataIn;
   logic          ram_we;
   logic          ram_rd;
   logic [DW-1:0] ram_dataOut = '0;
   logic          busy;

   ram_arbiter #(.AW(AW), .DW(DW)) dut (
      .clock       (clock),
      .reset       (reset),
      .req0        (req0),
      .req1        (req1),
      .wr0         (wr0),
      .wr1         (wr1),
      .addr0       (addr0),
      .addr1       (addr1),
      .wdata0      (wdata0),
      .wdata1      (wdata1),
      .ack0        (ack0),
      .ack1        (ack1),
      .rdata0      (rdata0),
      .rdata1      (rdata1),
      .ram_address (ram_address),
      .ram_dataIn  (ram_dataIn),
      .ram_we      (ram_we),
      .ram_rd      (ram_rd),
      .ram_dataOut (ram_dataOut),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   // External RAM: registered read, write on strobe
   logic [DW-1:0] mem [16] = '{1: 8'h0F, default: 8'h00};

   always @(posedge clock) begin
      if (ram_we)
         mem[ram_address] <= ram_dataIn;
      if (ram_rd)
         ram_dataOut <= mem[ram_address];
   end

   // Transaction model: one access = 4 cycles from sample
   logic [DW-1:0] m_mem [16] = '{1: 8'h0F, default: 8'h00};
   bit            m_active = 1'b0;
   int            m_age = 0;
   bit            m_w = 1'b0;
   bit            m_wr = 1'b0;
   bit            m_last = 1'b1;
   logic [DW-1:0] m_rd0 = '0;
   logic [DW-1:0] m_rd1 = '0;
   logic [AW-1:0] e_addr = '0;
   logic [DW-1:0] e_din = '0;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_active = 1'b0;
         m_age    = 0;
         m_last   = 1'b1;
         m_rd0    = '0;
         m_rd1    = '0;
         e_addr   = '0;
         e_din    = '0;
      end else if (!m_active) begin
         if (req0 || req1) begin
            if (req0 && req1)
               m_w = !m_last;
            else
               m_w = req1;
            m_last   = m_w;
            m_active = 1'b1;
            m_age    = 1;
            m_wr     = m_w ? wr1 : wr0;
            e_addr   = m_w ? addr1 : addr0;
            e_din    = m_w ? wdata1 : wdata0;
         end
      end else begin
         m_age++;
         if (m_age == 2 && m_wr)
            m_mem[e_addr] = e_din;
         if (m_age == 3 && !m_wr) begin
            if (m_w)
               m_rd1 = m_mem[e_addr];
            else
               m_rd0 = m_mem[e_addr];
         end
         if (m_age == 4)
            m_active = 1'b0;
      end
   end

   int total = 0;
   int bad = 0;
   bit chk_on = 1'b0;
   int ack_log [$];
   int rd_cnt = 0;
   int we_cnt = 0;
   int ovl_cnt = 0;
   int ack0_cnt = 0;
   int ack1_cnt = 0;

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic cycle_compare();
      logic in_issue;
      in_issue = m_active && (m_age == 1);
      check("ram_rd", ram_rd, in_issue && !m_wr);
      check("ram_we", ram_we, in_issue && m_wr);
      check("ack0", ack0, m_active && m_age == 3 && !m_w);
      check("ack1", ack1, m_active && m_age == 3 && m_w);
      check("busy", busy, m_active);
      check("ram_address", ram_address, e_addr);
      check("ram_dataIn", ram_dataIn, e_din);
      check("rdata0", rdata0, m_rd0);
      check("rdata1", rdata1, m_rd1);
   endtask

   task automatic drive(input int idx, input bit r,
                        input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
      if (idx == 0) begin
         req0 = r; wr0 = w; addr0 = a; wdata0 = d;
      end else begin
         req1 = r; wr1 = w; addr1 = a; wdata1 = d;
      end
   endtask

   task automatic access(input int idx, input bit w,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d,
                         input bit drop, output int lat);
      logic hit;
      lat = 0;
      @(negedge clock);
      drive(idx, 1'b1, w, a, d);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clock);
         if (drop && i == 1)
            drive(idx, 1'b0, w, a + 4'd2, ~d);
         hit = (idx == 0) ? ack0 : ack1;
         if (hit) begin
            lat = i;
            break;
         end
      end
      drive(idx, 1'b0, 1'b0, '0, '0);
      @(negedge clock);
   endtask

   int lat;
   int n0;
   int rd0;
   int we0;
   int a1s;
   int a0s;
   int ov0;
   int seq [4];

   initial begin
      seq[0] = 0; seq[1] = 1; seq[2] = 0; seq[3] = 1;
      fork
         forever begin
            @(negedge clock);
            if (chk_on)
               cycle_compare();
            if (ack0) begin ack_log.push_back(0); ack0_cnt++; end
            if (ack1) begin ack_log.push_back(1); ack1_cnt++; end
            if (ack0 && ack1) ovl_cnt++;
            if (ram_rd) rd_cnt++;
            if (ram_we) we_cnt++;
         end
         begin
            #50000;
            $display("FAIL watchdog t=%0t", $time);
            $fatal(1, "timeout");
         end
      join_none

      repeat (3) @(negedge clock);
      reset = 1'b1;
      chk_on = 1'b1;
      @(negedge clock);
      check("rst_busy", busy, 0);
      check("rst_ack0", ack0, 0);
      check("rst_rdata0", rdata0, 0);
      check("rst_addr", ram_address, 0);

      rd0 = rd_cnt;
      access(0, 1'b0, 4'd1, 8'h00, 1'b0, lat);
      check("rd_lat", lat, 3);
      check("rd_data", rdata0, 8'h0F);
      check("rd_strobe", rd_cnt - rd0, 1);

      we0 = we_cnt;
      a1s = ack1_cnt;
      access(1, 1'b1, 4'd7, 8'hA5, 1'b0, lat);
      check("wr_lat", lat, 3);
      access(1, 1'b0, 4'd7, 8'h00, 1'b0, lat);
      check("wr_rd_lat", lat, 3);
      check("wr_rdata1", rdata1, 8'hA5);
      check("wr_ack1_n", ack1_cnt - a1s, 2);
      check("wr_we_n", we_cnt - we0, 1);
      check("wr_rdata0", rdata0, 8'h0F);

      n0 = ack_log.size();
      ov0 = ovl_cnt;
      @(negedge clock);
      drive(0, 1'b1, 1'b0, 4'd7, 8'h00);
      drive(1, 1'b1, 1'b0, 4'd1, 8'h00);
      repeat (16) @(negedge clock);
      drive(0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0);
      repeat (6) @(negedge clock);
      check("tie_n", ack_log.size() - n0, 4);
      for (int i = 0; i < 4; i++)
         if (n0 + i < ack_log.size())
            check("tie_order", ack_log[n0 + i], seq[i]);
      check("tie_ovl", ovl_cnt - ov0, 0);
      check("tie_rdata0", rdata0, 8'hA5);
      check("tie_rdata1", rdata1, 8'h0F);

      a0s = ack0_cnt;
      @(negedge clock);
      drive(0, 1'b1, 1'b0, 4'd1, 8'h00);
      repeat (2) @(negedge clock);
      #1;
      check("ab_in_wait", busy, 1);
      reset = 1'b0;
      #1;
      check("ab_rd", ram_rd, 0);
      check("ab_we", ram_we, 0);
      check("ab_busy", busy, 0);
      check("ab_ack0", ack0, 0);
      check("ab_rdata0", rdata0, 0);
      drive(0, 1'b0, 1'b0, '0, '0);
      @(negedge clock);
      reset = 1'b1;
      repeat (4) @(negedge clock);
      check("ab_no_ack", ack0_cnt - a0s, 0);
      access(0, 1'b0, 4'd1, 8'h00, 1'b0, lat);
      check("ab_next_lat", lat, 3);
      check("ab_next_data", rdata0, 8'h0F);

      access(0, 1'b1, 4'd3, 8'h55, 1'b1, lat);
      check("drop_lat", lat, 3);
      check("drop_mem3", mem[3], 8'h55);
      check("drop_mem5", mem[5], 8'h00);
      check("drop_rdata0", rdata0, 8'h0F);

      repeat (2) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
